// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue handshake bundle: memory request/response, redirect and
// decode-side head port.
interface inst_fetch_queue_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_resp_valid,
        output mem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one-in-flight memory fetch feeding an
// in-order circular queue of {pc, inst} toward decode.
module inst_fetch_queue #(
    parameter int unsigned QUEUE_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam int unsigned CW    = QUEUE_DEPTH_LOG + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_e;

    state_e                     state_q;
    logic [31:0]                fetch_pc_q;
    logic [31:0]                fetch_pc_d;
    logic [QUEUE_DEPTH_LOG-1:0] head_q;
    logic [QUEUE_DEPTH_LOG-1:0] tail_q;
    logic [CW-1:0]              count_q;
    logic                       req_valid_q;
    logic [31:0]                req_addr_q;
    logic [31:0]                inst_mem_q [DEPTH];
    logic [31:0]                pc_mem_q   [DEPTH];

    logic out_valid;
    logic push;
    logic pop;

    assign out_valid  = (count_q != '0);
    assign fetch_pc_d = fetch_pc_q + 32'd4;

    // Redirect suppresses both queue movements in its cycle.
    assign push = (state_q == WAIT) && bus.mem_resp_valid
               && !bus.redirect_valid;
    assign pop  = out_valid && bus.out_ready
               && !bus.redirect_valid;

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_inst      = out_valid ? inst_mem_q[head_q] : 32'h0;
    assign bus.out_pc        = out_valid ? pc_mem_q[head_q]   : 32'h0;

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            inst_mem_q[tail_q] <= bus.mem_resp_data;
            pc_mem_q[tail_q]   <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'h0;
        end else if (rdy_in) begin
            if (bus.redirect_valid) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= bus.redirect_pc;
                unique case (state_q)
                    WAIT, DISCARD: begin
                        // The in-flight word belongs to the old path.
                        if (bus.mem_resp_valid) begin
                            req_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else begin
                if (pop) head_q <= head_q + 1'b1;
                if (push) tail_q <= tail_q + 1'b1;
                unique case (1'b1)
                    (push && !pop): count_q <= count_q + 1'b1;
                    (pop && !push): count_q <= count_q - 1'b1;
                    default:        count_q <= count_q;
                endcase
                unique case (state_q)
                    IDLE: begin
                        if (count_q != FULL) begin
                            req_addr_q  <= fetch_pc_q;
                            req_valid_q <= 1'b1;
                            state_q     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_resp_valid) begin
                            fetch_pc_q  <= fetch_pc_d;
                            req_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    DISCARD: begin
                        if (bus.mem_resp_valid) begin
                            req_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: expected {pc, inst} pairs are
// queued at response time and matched by a monitor at each accept.
module tb_inst_fetch_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   checks = 0;
    int   failures = 0;
    entry_t sb[$];

    inst_fetch_queue_if bus();

    inst_fetch_queue #(
        .QUEUE_DEPTH_LOG(3),
        .RESET_PC(32'h0)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rdy && !bus.redirect_valid
            && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop: got pc %h inst %h expected none",
                         bus.out_pc, bus.out_inst);
            end else begin
                entry_t e;
                e = sb.pop_front();
                if (bus.out_pc !== e.pc || bus.out_inst !== e.inst) begin
                    failures++;
                    $display("FAIL pop: got pc %h inst %h expected pc %h inst %h",
                             bus.out_pc, bus.out_inst, e.pc, e.inst);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_req(input logic [31:0] exp_addr,
                            output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: got none expected addr %h", exp_addr);
        end else begin
            check("req_addr", bus.mem_req_addr, exp_addr);
        end
    endtask

    task automatic respond(input logic [31:0] exp_addr,
                           input logic [31:0] data,
                           input int delay);
        bit ok;
        wait_req(exp_addr, ok);
        if (ok) begin
            repeat (delay) tick();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = data;
            sb.push_back({exp_addr, data});
            tick();
            bus.mem_resp_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        tick();
        bus.out_ready = 1'b0;
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        bit ok;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;

        // 1: reset state and first fetch latency
        do_reset();
        check("rst_req_valid", bus.mem_req_valid, 0);
        check("rst_req_addr", bus.mem_req_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_pc", bus.out_pc, 0);
        respond(32'h0, 32'h0050_0093, 2);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_inst", bus.out_inst, 32'h0050_0093);
        check("t1_out_pc", bus.out_pc, 32'h0);
        drain();

        // 2: fill to full, then one pop frees a slot
        do_reset();
        for (int i = 0; i < 8; i++)
            respond(32'(4 * i), 32'h1000_0000 + 32'(i), 0);
        repeat (5) tick();
        check("t2_full_no_req", bus.mem_req_valid, 0);
        check("t2_head_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        respond(32'h20, 32'h1000_0008, 1);
        drain();

        // 3: redirect while a request is outstanding
        do_reset();
        respond(32'h0, 32'h2000_0000, 0);
        respond(32'h4, 32'h2000_0004, 0);
        wait_req(32'h8, ok);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        sb.delete();
        check("t3_flushed", bus.out_valid, 0);
        check("t3_discard_hold", bus.mem_req_valid, 1);
        check("t3_discard_addr", bus.mem_req_addr, 32'h8);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("t3_dropped", bus.out_valid, 0);
        respond(32'h100, 32'h3000_0100, 1);
        drain();

        // 4: redirect + pop + response in the same cycle
        do_reset();
        respond(32'h0, 32'h4000_0000, 0);
        wait_req(32'h4, ok);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.out_ready      = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hBAD0_0004;
        tick();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        sb.delete();
        check("t4_count0", bus.out_valid, 0);
        check("t4_idle", bus.mem_req_valid, 0);
        respond(32'h40, 32'h4000_0040, 0);
        drain();

        // 5: rdy_in low freezes everything
        do_reset();
        for (int i = 0; i < 3; i++)
            respond(32'(4 * i), 32'h5000_0000 + 32'(i), 0);
        wait_req(32'hC, ok);
        rdy = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h800;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_frozen_pc", bus.out_pc, 32'h0);
        end
        check("t5_frozen_valid", bus.out_valid, 1);
        check("t5_frozen_inst", bus.out_inst, 32'h5000_0000);
        check("t5_frozen_addr", bus.mem_req_addr, 32'hC);
        bus.redirect_valid = 1'b0;
        rdy = 1'b1;
        drain();

        // 6: streaming across pointer wrap
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            respond(32'(4 * i), 32'h6000_0000 + 32'(i), i % 3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
